// File: rtl/game_timer_ctrl.sv
// Elapsed-time controller for the cartridge games: 1 s prescaler, 3-digit BCD seconds
// counter and IDLE/RUN/PAUSE/WON/OVER sequencing. Define GAME_TIMER_BEST_EN for best-time tracking.
`timescale 1ns/1ps

module game_timer_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic       pause_tgl,
    input  logic       game_won,
    input  logic       game_over,
    input  logic       clr,
    output logic [2:0] state,
    output logic       running,
    output logic       tick_1s,
    output logic [3:0] time_1s,
    output logic [3:0] time_10s,
    output logic [3:0] time_100s,
    output logic       time_max_flag,
    output logic       final_valid
`ifdef GAME_TIMER_BEST_EN
    ,
    output logic [3:0] best_1s,
    output logic [3:0] best_10s,
    output logic [3:0] best_100s,
    output logic       best_valid
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        WON   = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    state_t           cur_state, next_state;
    logic [CNT_W-1:0] presc, next_presc;
    logic [3:0]       next_1s, next_10s, next_100s;
    logic [3:0]       inc_1s, inc_10s, inc_100s;
    logic             next_flag, next_tick;
    logic             tick_due, at_max;

    assign state    = cur_state;
    assign tick_due = (presc == PRESC_LAST);
    assign at_max   = (time_1s == 4'd9) && (time_10s == 4'd9) && (time_100s == 4'd9);

    // BCD increment with ripple carry; the 999 case is caught by at_max before use
    always_comb begin
        inc_1s   = time_1s + 4'd1;
        inc_10s  = time_10s;
        inc_100s = time_100s;
        if (time_1s == 4'd9) begin
            inc_1s = 4'd0;
            if (time_10s == 4'd9) begin
                inc_10s  = 4'd0;
                inc_100s = (time_100s == 4'd9) ? 4'd0 : time_100s + 4'd1;
            end else begin
                inc_10s = time_10s + 4'd1;
            end
        end
    end

    always_comb begin
        next_state = cur_state;
        next_presc = presc;
        next_1s    = time_1s;
        next_10s   = time_10s;
        next_100s  = time_100s;
        next_flag  = time_max_flag;
        next_tick  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    next_presc = '0;
                    next_1s    = 4'd0;
                    next_10s   = 4'd0;
                    next_100s  = 4'd0;
                    next_flag  = 1'b0;
                end
            end
            RUN: begin
                if (game_over) begin
                    next_state = OVER;
                end else if (game_won) begin
                    next_state = WON;
                end else if (tick_due && at_max) begin
                    next_state = OVER;
                    next_presc = '0;
                    next_flag  = 1'b1;
                    next_tick  = 1'b1;
                end else if (pause_tgl) begin
                    next_state = PAUSE;
                end else if (tick_due) begin
                    next_presc = '0;
                    next_tick  = 1'b1;
                    next_1s    = inc_1s;
                    next_10s   = inc_10s;
                    next_100s  = inc_100s;
                end else begin
                    next_presc = presc + 1'b1;
                end
            end
            PAUSE: begin
                if (game_over) begin
                    next_state = OVER;
                end else if (game_won) begin
                    next_state = WON;
                end else if (pause_tgl) begin
                    next_state = RUN;
                end
            end
            WON, OVER: begin
                if (clr) begin
                    next_state = IDLE;
                    next_presc = '0;
                    next_1s    = 4'd0;
                    next_10s   = 4'd0;
                    next_100s  = 4'd0;
                    next_flag  = 1'b0;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_state     <= IDLE;
            presc         <= '0;
            time_1s       <= 4'd0;
            time_10s      <= 4'd0;
            time_100s     <= 4'd0;
            time_max_flag <= 1'b0;
            tick_1s       <= 1'b0;
            running       <= 1'b0;
            final_valid   <= 1'b0;
        end else begin
            cur_state     <= next_state;
            presc         <= next_presc;
            time_1s       <= next_1s;
            time_10s      <= next_10s;
            time_100s     <= next_100s;
            time_max_flag <= next_flag;
            tick_1s       <= next_tick;
            running       <= (next_state == RUN);
            final_valid   <= (next_state == WON) || (next_state == OVER);
        end
    end

`ifdef GAME_TIMER_BEST_EN
    logic        win_edge;
    logic [11:0] cur_time, best_time;

    // Packed BCD digits compare in the same order as the numeric value
    assign win_edge  = ((cur_state == RUN) || (cur_state == PAUSE)) && (next_state == WON);
    assign cur_time  = {time_100s, time_10s, time_1s};
    assign best_time = {best_100s, best_10s, best_1s};

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            best_1s    <= 4'd0;
            best_10s   <= 4'd0;
            best_100s  <= 4'd0;
            best_valid <= 1'b0;
        end else if (win_edge && (!best_valid || (cur_time < best_time))) begin
            best_1s    <= time_1s;
            best_10s   <= time_10s;
            best_100s  <= time_100s;
            best_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Directed self-checking bench for game_timer_ctrl with TICK_DIV=4.
// Best-time checks are compiled in when GAME_TIMER_BEST_EN is defined.
`timescale 1ns/1ps

module tb_game_timer_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0, pause_tgl = 1'b0, game_won = 1'b0, game_over = 1'b0, clr = 1'b0;
    logic [2:0]  state;
    logic        running, tick_1s, time_max_flag, final_valid;
    logic [3:0]  time_1s, time_10s, time_100s;
    logic [11:0] digits;
`ifdef GAME_TIMER_BEST_EN
    logic [3:0]  best_1s, best_10s, best_100s;
    logic        best_valid;
    logic [11:0] best;
    assign best = {best_100s, best_10s, best_1s};
`endif

    int pass_cnt = 0;
    int check_cnt = 0;

    assign digits = {time_100s, time_10s, time_1s};

    game_timer_ctrl #(.TICK_DIV(4), .CNT_W(4)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .pause_tgl(pause_tgl),
        .game_won(game_won), .game_over(game_over), .clr(clr), .state(state),
        .running(running), .tick_1s(tick_1s), .time_1s(time_1s), .time_10s(time_10s),
        .time_100s(time_100s), .time_max_flag(time_max_flag), .final_valid(final_valid)
`ifdef GAME_TIMER_BEST_EN
        , .best_1s(best_1s), .best_10s(best_10s), .best_100s(best_100s), .best_valid(best_valid)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change and outputs are sampled 1 ns after the rising edge
    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(1); start = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1; step(1); clr = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_tgl = 1'b1; step(1); pause_tgl = 1'b0;
    endtask

    task automatic pulse_over();
        game_over = 1'b1; step(1); game_over = 1'b0;
    endtask

    task automatic test_reset();
        check_cnt++; if (state !== 3'd0) $display("[TB] FAIL reset_state: got %0d expected 0", state); else pass_cnt++;
        check_cnt++; if (running !== 1'b0) $display("[TB] FAIL reset_running: got %b expected 0", running); else pass_cnt++;
        check_cnt++; if (tick_1s !== 1'b0) $display("[TB] FAIL reset_tick: got %b expected 0", tick_1s); else pass_cnt++;
        check_cnt++; if (digits !== 12'h000) $display("[TB] FAIL reset_digits: got %h expected 000", digits); else pass_cnt++;
        check_cnt++; if (time_max_flag !== 1'b0) $display("[TB] FAIL reset_flag: got %b expected 0", time_max_flag); else pass_cnt++;
        check_cnt++; if (final_valid !== 1'b0) $display("[TB] FAIL reset_final: got %b expected 0", final_valid); else pass_cnt++;
    endtask

    task automatic test_count();
        int ticks = 0;
        int bad_cycle = 0;
        pulse_start();
        check_cnt++; if (state !== 3'd1) $display("[TB] FAIL count_enter_run: got %0d expected 1", state); else pass_cnt++;
        check_cnt++; if (running !== 1'b1) $display("[TB] FAIL count_running: got %b expected 1", running); else pass_cnt++;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            if (tick_1s) ticks++;
            if (tick_1s !== ((i % 4) == 0) && bad_cycle == 0) bad_cycle = i;
        end
        check_cnt++; if (bad_cycle != 0) $display("[TB] FAIL count_tick_timing: got wrong tick at cycle %0d expected every 4th", bad_cycle); else pass_cnt++;
        check_cnt++; if (ticks != 10) $display("[TB] FAIL count_ticks: got %0d expected 10", ticks); else pass_cnt++;
        check_cnt++; if (digits !== 12'h010) $display("[TB] FAIL count_digits: got %h expected 010", digits); else pass_cnt++;
        pulse_over();
        check_cnt++; if (state !== 3'd4) $display("[TB] FAIL count_over: got %0d expected 4", state); else pass_cnt++;
        pulse_clr();
        check_cnt++; if (state !== 3'd0) $display("[TB] FAIL count_clr_state: got %0d expected 0", state); else pass_cnt++;
        check_cnt++; if (final_valid !== 1'b0) $display("[TB] FAIL count_clr_final: got %b expected 0", final_valid); else pass_cnt++;
    endtask

    task automatic test_pause();
        int ticks = 0;
        pulse_start();
        step(2);
        pulse_pause();
        check_cnt++; if (state !== 3'd2) $display("[TB] FAIL pause_state: got %0d expected 2", state); else pass_cnt++;
        check_cnt++; if (running !== 1'b0) $display("[TB] FAIL pause_running: got %b expected 0", running); else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) start = 1'b1;
            step(1);
            start = 1'b0;
            if (tick_1s) ticks++;
        end
        check_cnt++; if (ticks != 0) $display("[TB] FAIL pause_no_tick: got %0d expected 0", ticks); else pass_cnt++;
        check_cnt++; if (state !== 3'd2) $display("[TB] FAIL pause_start_ignored: got %0d expected 2", state); else pass_cnt++;
        pulse_pause();
        check_cnt++; if (state !== 3'd1) $display("[TB] FAIL resume_state: got %0d expected 1", state); else pass_cnt++;
        step(1);
        check_cnt++; if (tick_1s !== 1'b0) $display("[TB] FAIL resume_early_tick: got %b expected 0", tick_1s); else pass_cnt++;
        step(1);
        check_cnt++; if (tick_1s !== 1'b1) $display("[TB] FAIL resume_tick: got %b expected 1", tick_1s); else pass_cnt++;
        check_cnt++; if (digits !== 12'h001) $display("[TB] FAIL resume_digits: got %h expected 001", digits); else pass_cnt++;
        pulse_over();
        pulse_clr();
    endtask

    task automatic test_saturation();
        pulse_start();
        step(3996);
        check_cnt++; if (digits !== 12'h999) $display("[TB] FAIL sat_reach_999: got %h expected 999", digits); else pass_cnt++;
        check_cnt++; if (time_max_flag !== 1'b0) $display("[TB] FAIL sat_flag_early: got %b expected 0", time_max_flag); else pass_cnt++;
        step(3);
        check_cnt++; if (state !== 3'd1) $display("[TB] FAIL sat_still_run: got %0d expected 1", state); else pass_cnt++;
        step(1);
        check_cnt++; if (state !== 3'd4) $display("[TB] FAIL sat_state: got %0d expected 4", state); else pass_cnt++;
        check_cnt++; if (digits !== 12'h999) $display("[TB] FAIL sat_digits: got %h expected 999", digits); else pass_cnt++;
        check_cnt++; if (time_max_flag !== 1'b1) $display("[TB] FAIL sat_flag: got %b expected 1", time_max_flag); else pass_cnt++;
        check_cnt++; if (final_valid !== 1'b1) $display("[TB] FAIL sat_final: got %b expected 1", final_valid); else pass_cnt++;
        step(8);
        check_cnt++; if (digits !== 12'h999) $display("[TB] FAIL sat_frozen: got %h expected 999", digits); else pass_cnt++;
        pulse_clr();
        check_cnt++; if (state !== 3'd0) $display("[TB] FAIL sat_clr_state: got %0d expected 0", state); else pass_cnt++;
        check_cnt++; if (digits !== 12'h000) $display("[TB] FAIL sat_clr_digits: got %h expected 000", digits); else pass_cnt++;
        check_cnt++; if (time_max_flag !== 1'b0) $display("[TB] FAIL sat_clr_flag: got %b expected 0", time_max_flag); else pass_cnt++;
    endtask

    task automatic test_won_over_tick();
        pulse_start();
        step(60);
        check_cnt++; if (digits !== 12'h015) $display("[TB] FAIL wo_reach_015: got %h expected 015", digits); else pass_cnt++;
        step(3);
        game_won = 1'b1; game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        check_cnt++; if (state !== 3'd4) $display("[TB] FAIL wo_state: got %0d expected 4", state); else pass_cnt++;
        check_cnt++; if (digits !== 12'h015) $display("[TB] FAIL wo_digits: got %h expected 015", digits); else pass_cnt++;
        check_cnt++; if (tick_1s !== 1'b0) $display("[TB] FAIL wo_tick_dropped: got %b expected 0", tick_1s); else pass_cnt++;
        check_cnt++; if (final_valid !== 1'b1) $display("[TB] FAIL wo_final: got %b expected 1", final_valid); else pass_cnt++;
        step(3);
        game_won = 1'b0;
        pulse_start();
        step(5);
        check_cnt++; if (state !== 3'd4) $display("[TB] FAIL wo_start_ignored: got %0d expected 4", state); else pass_cnt++;
        check_cnt++; if (digits !== 12'h015) $display("[TB] FAIL wo_still_frozen: got %h expected 015", digits); else pass_cnt++;
        pulse_clr();
    endtask

    task automatic test_async_reset();
        pulse_start();
        step(492);
        check_cnt++; if (digits !== 12'h123) $display("[TB] FAIL ar_reach_123: got %h expected 123", digits); else pass_cnt++;
        step(2);
        #2 sys_rst_n = 1'b0;
        #1;
        check_cnt++; if (state !== 3'd0) $display("[TB] FAIL ar_state: got %0d expected 0", state); else pass_cnt++;
        check_cnt++; if (running !== 1'b0) $display("[TB] FAIL ar_running: got %b expected 0", running); else pass_cnt++;
        check_cnt++; if (digits !== 12'h000) $display("[TB] FAIL ar_digits: got %h expected 000", digits); else pass_cnt++;
        check_cnt++; if ({tick_1s, time_max_flag, final_valid} !== 3'b000) $display("[TB] FAIL ar_flags: got %b expected 000", {tick_1s, time_max_flag, final_valid}); else pass_cnt++;
        step(1);
        sys_rst_n = 1'b1;
        step(1);
        pulse_start();
        step(3);
        check_cnt++; if (digits !== 12'h000) $display("[TB] FAIL ar_restart_zero: got %h expected 000", digits); else pass_cnt++;
        step(1);
        check_cnt++; if (digits !== 12'h001) $display("[TB] FAIL ar_restart_one: got %h expected 001", digits); else pass_cnt++;
        pulse_over();
        pulse_clr();
    endtask

`ifdef GAME_TIMER_BEST_EN
    task automatic test_best();
        sys_rst_n = 1'b0;
        step(1);
        sys_rst_n = 1'b1;
        step(1);
        check_cnt++; if ({best_valid, best} !== 13'h0000) $display("[TB] FAIL best_reset: got %h expected 0000", {best_valid, best}); else pass_cnt++;
        pulse_start(); step(120); game_won = 1'b1; step(1); game_won = 1'b0;
        check_cnt++; if (best !== 12'h030) $display("[TB] FAIL best_first: got %h expected 030", best); else pass_cnt++;
        check_cnt++; if (best_valid !== 1'b1) $display("[TB] FAIL best_valid: got %b expected 1", best_valid); else pass_cnt++;
        pulse_clr();
        check_cnt++; if (best !== 12'h030) $display("[TB] FAIL best_clr_keep: got %h expected 030", best); else pass_cnt++;
        pulse_start(); step(180); game_won = 1'b1; step(1); game_won = 1'b0;
        check_cnt++; if (best !== 12'h030) $display("[TB] FAIL best_slower: got %h expected 030", best); else pass_cnt++;
        pulse_clr();
        pulse_start(); step(48); game_won = 1'b1; step(1); game_won = 1'b0;
        check_cnt++; if (best !== 12'h012) $display("[TB] FAIL best_faster: got %h expected 012", best); else pass_cnt++;
        pulse_clr();
        pulse_start(); step(20); pulse_over();
        check_cnt++; if (best !== 12'h012) $display("[TB] FAIL best_loss: got %h expected 012", best); else pass_cnt++;
        pulse_clr();
    endtask
`endif

    initial begin
        step(2);
        test_reset();
        sys_rst_n = 1'b1;
        step(1);
        test_count();
        test_pause();
        test_saturation();
        test_won_over_tick();
        test_async_reset();
`ifdef GAME_TIMER_BEST_EN
        test_best();
`endif
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
